// File: rtl/braille_pkg.sv
// Shared definitions for the Braille trainer round sequencer.
//   state_e        : sequencer states
//   BRAILLE_LUT    : expected 4-dot cell for letters a..j
//   next_target()  : advances the letter index by TARGET_STRIDE modulo NUM_LETTERS
package braille_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CLEAR    = 3'd1,
    ST_WAIT     = 3'd2,
    ST_JUDGE    = 3'd3,
    ST_FEEDBACK = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

  localparam int NUM_LETTERS   = 10;
  localparam int TARGET_STRIDE = 3;

  // Bit positions of the dots within a 4-bit pattern.
  localparam int DOT1_BIT = 0;
  localparam int DOT2_BIT = 1;
  localparam int DOT4_BIT = 2;
  localparam int DOT5_BIT = 3;

  // Letters a..j, bit order {dot5, dot4, dot2, dot1}.
  localparam logic [3:0] BRAILLE_LUT [NUM_LETTERS] = '{
    4'b0001, 4'b0011, 4'b0101, 4'b1101, 4'b1001,
    4'b0111, 4'b1111, 4'b1011, 4'b0110, 4'b1110
  };

  function automatic logic [3:0] next_target(input logic [3:0] cur);
    logic [4:0] sum;
    sum = {1'b0, cur} + 5'(TARGET_STRIDE);
    if (sum >= 5'(NUM_LETTERS)) sum = sum - 5'(NUM_LETTERS);
    return sum[3:0];
  endfunction

endpackage

// File: rtl/trainer_timer.sv
// Clearable up-counter with terminal-count compare, shared by the response
// window and the feedback hold.
//   Clk, Rst   : clock, async active-low reset
//   clr_i      : synchronous clear to zero (wins over enable)
//   en_i       : count enable
//   tc_val_i   : terminal value (period - 1)
//   tc_o       : high while enabled and count equals tc_val_i
//   cnt_o      : current count
module trainer_timer #(
  parameter int W = 8
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] tc_val_i,
  output logic         tc_o,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)       cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i)  cnt_q <= cnt_q + 1'b1;
  end

  assign tc_o  = en_i && (cnt_q == tc_val_i);
  assign cnt_o = cnt_q;

endmodule

// File: rtl/braille_round_ctrl.sv
// Round sequencer for the Braille trainer: picks the target letter, re-arms
// the pattern-load register, judges the loaded pattern, enforces a response
// timeout and keeps score over NUM_ROUNDS rounds.
//   Clk, Rst               : clock, async active-low reset
//   Start                  : begins a session from IDLE or DONE
//   PatIn, PatEn           : pattern and loaded flag from the load register
//   LoadRst                : active-low clear to the load register
//   Target                 : current letter index 0..9
//   ResOk, ResBad, ResTo   : result lamps, only lit in FEEDBACK
//   Score, Round, Done     : session progress
//
// state    | meaning
// IDLE     | waiting for Start, load register held clear
// CLEAR    | one cycle to clear load register and timer
// WAIT     | accepting a pattern, response window running
// JUDGE    | compare captured pattern with expected cell
// FEEDBACK | result lamp held for FB_CYCLES
// DONE     | session over, score held until Start
module braille_round_ctrl
  import braille_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int FB_CYCLES      = 25_000_000,
  parameter int NUM_ROUNDS     = 10
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Start,
  input  logic [3:0] PatIn,
  input  logic       PatEn,
  output logic       LoadRst,
  output logic [3:0] Target,
  output logic       ResOk,
  output logic       ResBad,
  output logic       ResTo,
  output logic [3:0] Score,
  output logic [3:0] Round,
  output logic       Done
);

  localparam int MAX_CYC = (TIMEOUT_CYCLES > FB_CYCLES) ? TIMEOUT_CYCLES : FB_CYCLES;
  localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  state_e     state_q, state_d;
  logic [3:0] score_q, score_d;
  logic [3:0] round_q, round_d;
  logic [3:0] target_q, target_d;
  logic [3:0] cap_q, cap_d;
  logic       ok_q, ok_d, bad_q, bad_d, to_q, to_d;

  logic          tmr_clr, tmr_en, tmr_tc;
  logic [TW-1:0] tmr_tc_val, tmr_cnt;

  // The timer restarts on every state change, so each WAIT and FEEDBACK
  // visit starts counting from zero.
  assign tmr_clr    = (state_d != state_q);
  assign tmr_en     = (state_q == ST_WAIT) || (state_q == ST_FEEDBACK);
  assign tmr_tc_val = (state_q == ST_WAIT) ? TW'(TIMEOUT_CYCLES - 1) : TW'(FB_CYCLES - 1);

  trainer_timer #(.W(TW)) u_timer (
    .Clk      (Clk),
    .Rst      (Rst),
    .clr_i    (tmr_clr),
    .en_i     (tmr_en),
    .tc_val_i (tmr_tc_val),
    .tc_o     (tmr_tc),
    .cnt_o    (tmr_cnt)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= ST_IDLE;
      score_q  <= '0;
      round_q  <= '0;
      target_q <= '0;
      cap_q    <= '0;
      ok_q     <= 1'b0;
      bad_q    <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      score_q  <= score_d;
      round_q  <= round_d;
      target_q <= target_d;
      cap_q    <= cap_d;
      ok_q     <= ok_d;
      bad_q    <= bad_d;
      to_q     <= to_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    score_d  = score_q;
    round_d  = round_q;
    target_d = target_q;
    cap_d    = cap_q;
    ok_d     = 1'b0;
    bad_d    = 1'b0;
    to_d     = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (Start) begin
          state_d  = ST_CLEAR;
          score_d  = '0;
          round_d  = '0;
          target_d = '0;
        end
      end
      ST_CLEAR: state_d = ST_WAIT;
      ST_WAIT: begin
        // A press on the last window cycle still counts.
        if (PatEn) begin
          state_d = ST_JUDGE;
          cap_d   = PatIn;
        end else if (tmr_tc) begin
          state_d = ST_FEEDBACK;
          to_d    = 1'b1;
        end
      end
      ST_JUDGE: begin
        state_d = ST_FEEDBACK;
        if (cap_q == BRAILLE_LUT[target_q]) begin
          ok_d = 1'b1;
          if (score_q != 4'hF) score_d = score_q + 4'd1;
        end else begin
          bad_d = 1'b1;
        end
      end
      ST_FEEDBACK: begin
        ok_d  = ok_q;
        bad_d = bad_q;
        to_d  = to_q;
        if (tmr_tc) begin
          ok_d  = 1'b0;
          bad_d = 1'b0;
          to_d  = 1'b0;
          if (round_q == 4'(NUM_ROUNDS - 1)) begin
            state_d = ST_DONE;
          end else begin
            state_d  = ST_CLEAR;
            round_d  = round_q + 4'd1;
            target_d = next_target(target_q);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign LoadRst = (state_q == ST_WAIT) || (state_q == ST_JUDGE);
  assign Done    = (state_q == ST_DONE);
  assign Target  = target_q;
  assign Score   = score_q;
  assign Round   = round_q;
  assign ResOk   = ok_q;
  assign ResBad  = bad_q;
  assign ResTo   = to_q;

endmodule

// File: doc/braille_round_ctrl.md
# braille_round_ctrl

Round sequencer for the Braille trainer. It selects the target letter (a–j) for each round and re-arms the 4-bit pattern-load register before each attempt. It judges the loaded dot pattern against the expected cell, enforces a response timeout, and keeps score over a fixed number of rounds. It sits between the user Start button and the existing pattern-load register, whose data/enable outputs it consumes and whose active-low clear it drives.

## Interface
- TIMEOUT_CYCLES, 50_000_000, cycles allowed per attempt in WAIT (≥2)
- FB_CYCLES, 25_000_000, cycles the result is held in FEEDBACK (≥1)
- NUM_ROUNDS, 10, rounds per session (1..15)

- Clk  in  1  clock; single clock domain
- Rst  in  1  reset, asynchronous, active-low
- Start  in  1  synchronous level/pulse; begins a session from IDLE or DONE
- PatIn  in  4  loaded pattern from load register; [0]=dot1 [1]=dot2 [2]=dot4 [3]=dot5
- PatEn  in  1  load register "pattern loaded" flag (sticky until cleared)
- LoadRst  out  1  active-low synchronous clear to load register
- Target  out  4  current letter index 0..9 (a..j)
- ResOk / ResBad / ResTo  out  1 each  result lamps, valid in FEEDBACK only
- Score  out  4  correct answers this session
- Round  out  4  current round index 0..NUM_ROUNDS-1
- Done  out  1  session complete

## Operation
- States: IDLE, CLEAR, WAIT, JUDGE, FEEDBACK, DONE.
- IDLE: Start=1 → CLEAR; Score, Round, Target := 0.
- CLEAR: timer := 0; → WAIT unconditionally (one cycle).
- WAIT: timer increments.
  - PatEn=1 → JUDGE; capture PatIn.
  - Otherwise timer==TIMEOUT_CYCLES-1 → FEEDBACK with ResTo.
  - PatEn=1 on the timeout cycle: PatEn wins.
- JUDGE (one cycle): compare capture with LUT[Target].
  - Equal → ResOk, Score+1.
  - Else → ResBad.
  - → FEEDBACK with timer := 0.
- FEEDBACK: lamps held for FB_CYCLES cycles, then:
  - Round==NUM_ROUNDS-1 → DONE.
  - Else Round+1, Target := (Target+3) mod 10, → CLEAR.
- DONE: Done=1; Score and Round hold. Start=1 → CLEAR with Score, Round, Target := 0.
- Start is ignored in CLEAR, WAIT, JUDGE and FEEDBACK.
- Target sequence: 0,3,6,9,2,5,8,1,4,7,…
- LUT (a..j): 0001, 0011, 0101, 1101, 1001, 0111, 1111, 1011, 0110, 1110.
- LoadRst = 0 in IDLE, CLEAR, FEEDBACK and DONE; 1 in WAIT and JUDGE. Presses outside WAIT are discarded.
- Exactly one of ResOk/ResBad/ResTo is 1 in FEEDBACK; all are 0 elsewhere.
- Score saturates at 15; this is unreachable with NUM_ROUNDS ≤ 15.

## Timing
- Reset (Rst=0, asynchronous) at any time, including mid-round:
  - State → IDLE.
  - Score, Round, Target, timer, capture → 0.
  - ResOk/ResBad/ResTo, Done → 0.
  - LoadRst → 0.
- State, counters and result lamps are registered. LoadRst and Done are decoded from the state register only (Moore).
- The load register clears on the Clk edge that leaves CLEAR, so PatEn is 0 in the first WAIT cycle.
- Latency:
  - PatEn high in WAIT → JUDGE next cycle.
  - JUDGE → lamp high the following cycle.
- Timeout: WAIT lasts exactly TIMEOUT_CYCLES cycles with no PatEn.
- FEEDBACK lasts exactly FB_CYCLES cycles.
- Score updates on the JUDGE→FEEDBACK edge. Round and Target update on the FEEDBACK→CLEAR edge.

## Structure
- Package braille_pkg:
  - state enum.
  - BRAILLE_LUT constant array (10×4).
  - TARGET_STRIDE=3, NUM_LETTERS=10.
  - Dot-bit index constants.
- Sub-module trainer_timer: clearable up-counter with terminal-count compare. It is shared by WAIT (TIMEOUT_CYCLES) and FEEDBACK (FB_CYCLES); the width is derived from the larger parameter.
- Remaining logic (FSM, score, round, target) lives in braille_round_ctrl.

## Test plan
Parameters for all scenarios: TIMEOUT_CYCLES=20, FB_CYCLES=4, NUM_ROUNDS=3.
- Reset/idle: hold Rst=0 then release. All outputs 0, LoadRst=0, state IDLE. PatEn=1 in IDLE → no state change.
- Correct answer: Start; round 0 Target=0; PatEn=1 with PatIn=0001 in 3rd WAIT cycle. → ResOk for 4 cycles, Score=1; → CLEAR, Round=1, Target=3, LoadRst pulses low.
- Wrong answer: Target=3 (d); PatIn=1001 (e). → ResBad, Score unchanged.
- Timeout: no PatEn for 20 WAIT cycles. → ResTo on the 21st cycle. PatEn asserted on cycle 20 gives JUDGE instead (priority).
- Full session: answer correct, wrong, timeout. → Done=1, Score=1, Round=2. Start → Score=0, Round=0, Target=0.
- Reset mid-FEEDBACK: assert Rst asynchronously between edges. Lamps and Score clear immediately; state IDLE after release.
